// File: rtl/instruction_mem_loader.sv
// Framed byte-stream loader for instruction memory: length, L instruction bytes, XOR checksum.
// Each accepted instruction byte is written one cycle later at BASE_ADDR + index.
module instruction_mem_loader #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LENGTH,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE_D  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO_D = '0;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   remaining;
  logic [DATA_WIDTH-1:0]   checksum;
  logic [ADDR_WIDTH-1:0]   index;
  logic                    we_q;
  logic                    xfer;

  assign xfer = in_valid && in_ready;

  // A pending write pulse is masked while reset is asserted so an abort never lands in memory.
  assign mem_we = we_q && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LENGTH;
        end
      end
      S_LENGTH: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          state_next = (in_data == ZERO_D) ? S_ERROR : S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && (remaining == ONE_D)) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          state_next = (in_data == checksum) ? S_DONE : S_ERROR;
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        if (start) begin
          state_next = S_LENGTH;
        end
      end
      S_ERROR: begin
        load_error = 1'b1;
        if (start) begin
          state_next = S_LENGTH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      checksum  <= '0;
      index     <= '0;
      we_q      <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        S_LENGTH: begin
          if (xfer && (in_data != ZERO_D)) begin
            remaining <= in_data;
            checksum  <= '0;
            index     <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            // Address wraps naturally modulo 2^ADDR_WIDTH.
            checksum  <= checksum ^ in_data;
            index     <= index + ONE_A;
            remaining <= remaining - ONE_D;
            we_q      <= 1'b1;
            mem_addr  <= BASE_ADDR + index;
            mem_wdata <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
